morse_decoder: RTL and testbench

// Receive-side companion to the Morse encoder. Samples the serial on/off key line (one bit per clk),

---
 rtl/morse_decoder_pkg.sv | 46 ++++
 rtl/morse_pattern_lut.sv | 47 ++++
 rtl/morse_decoder.sv | 151 +++++++++++++++
 tb/tb_morse_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_decoder_pkg.sv
// Shared definitions for the Morse receive path: letter codes (same map as the
// encoder's {sw1,sw0,btn3,btn2,btn1} input), FSM states and element bit meanings.
package morse_decoder_pkg;

  // Letter codes: seven letters per bank of eight, code 0 of each bank unused.
  localparam logic [4:0] L_A = 5'b00001;
  localparam logic [4:0] L_B = 5'b00010;
  localparam logic [4:0] L_C = 5'b00011;
  localparam logic [4:0] L_D = 5'b00100;
  localparam logic [4:0] L_E = 5'b00101;
  localparam logic [4:0] L_F = 5'b00110;
  localparam logic [4:0] L_G = 5'b00111;
  localparam logic [4:0] L_H = 5'b01001;
  localparam logic [4:0] L_I = 5'b01010;
  localparam logic [4:0] L_J = 5'b01011;
  localparam logic [4:0] L_K = 5'b01100;
  localparam logic [4:0] L_L = 5'b01101;
  localparam logic [4:0] L_M = 5'b01110;
  localparam logic [4:0] L_N = 5'b01111;
  localparam logic [4:0] L_O = 5'b10001;
  localparam logic [4:0] L_P = 5'b10010;
  localparam logic [4:0] L_Q = 5'b10011;
  localparam logic [4:0] L_R = 5'b10100;
  localparam logic [4:0] L_S = 5'b10101;
  localparam logic [4:0] L_T = 5'b10110;
  localparam logic [4:0] L_U = 5'b10111;
  localparam logic [4:0] L_V = 5'b11001;
  localparam logic [4:0] L_W = 5'b11010;
  localparam logic [4:0] L_X = 5'b11011;
  localparam logic [4:0] L_Y = 5'b11100;
  localparam logic [4:0] L_Z = 5'b11101;

  // Element encoding inside the pattern shift register.
  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  localparam logic [2:0] MAX_ELEMS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MARK     = 2'd1,
    ST_SPACE    = 2'd2,
    ST_ERR_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/morse_pattern_lut.sv
// Combinational letter lookup: element count plus dot/dash pattern (first
// element in the highest used bit, unused upper bits zero) -> letter code.
module morse_pattern_lut
  import morse_decoder_pkg::*;
(
  input  logic [2:0] elem_cnt,
  input  logic [3:0] pattern,
  output logic       hit,
  output logic [4:0] code
);

  // Map each assigned (count, pattern) pair to its letter; anything else misses.
  always_comb begin
    hit  = 1'b1;
    code = 5'd0;
    case ({elem_cnt, pattern})
      {3'd1, 4'b0000}: code = L_E;
      {3'd1, 4'b0001}: code = L_T;
      {3'd2, 4'b0000}: code = L_I;
      {3'd2, 4'b0001}: code = L_A;
      {3'd2, 4'b0010}: code = L_N;
      {3'd2, 4'b0011}: code = L_M;
      {3'd3, 4'b0000}: code = L_S;
      {3'd3, 4'b0001}: code = L_U;
      {3'd3, 4'b0010}: code = L_R;
      {3'd3, 4'b0011}: code = L_W;
      {3'd3, 4'b0100}: code = L_D;
      {3'd3, 4'b0101}: code = L_K;
      {3'd3, 4'b0110}: code = L_G;
      {3'd3, 4'b0111}: code = L_O;
      {3'd4, 4'b0000}: code = L_H;
      {3'd4, 4'b0001}: code = L_V;
      {3'd4, 4'b0010}: code = L_F;
      {3'd4, 4'b0100}: code = L_L;
      {3'd4, 4'b0110}: code = L_P;
      {3'd4, 4'b0111}: code = L_J;
      {3'd4, 4'b1000}: code = L_B;
      {3'd4, 4'b1001}: code = L_X;
      {3'd4, 4'b1010}: code = L_C;
      {3'd4, 4'b1011}: code = L_Y;
      {3'd4, 4'b1100}: code = L_Z;
      {3'd4, 4'b1101}: code = L_Q;
      default:         hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: registers the key line, measures mark/space run lengths,
// collects up to four dot/dash elements and emits a letter code at a letter gap.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | line quiet, no letter in progress
// ST_MARK     | key down, run counts mark length
// ST_SPACE    | key up inside a letter, run counts space length
// ST_ERR_WAIT | letter discarded, waiting for a letter gap before resuming
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int unsigned DOT_MAX  = 1,
  parameter int unsigned DASH_MAX = 4,
  parameter int unsigned GAP_MIN  = 3,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic       err,
  output logic       busy
);

  localparam logic [CW-1:0] RUN_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] DOT_LIM    = CW'(DOT_MAX);
  localparam logic [CW-1:0] DASH_LIM   = CW'(DASH_MAX);
  localparam logic [CW-1:0] GAP_LIM    = CW'(GAP_MIN);
  localparam logic [CW-1:0] RUN_ONE    = CW'(1);

  state_e        state_q, state_d;
  logic          key_q;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] run_inc;
  logic [2:0]    elem_cnt_q, elem_cnt_d;
  logic [3:0]    pattern_q, pattern_d;
  logic          letter_valid_q, letter_valid_d;
  logic          err_q, err_d;
  logic [4:0]    letter_code_q, letter_code_d;
  logic          lut_hit;
  logic [4:0]    lut_code;

  morse_pattern_lut u_lut (
    .elem_cnt (elem_cnt_q),
    .pattern  (pattern_q),
    .hit      (lut_hit),
    .code     (lut_code)
  );

  // Run counter holds at full scale so an endless mark stays a (too long) mark.
  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

  // Next-state, run/element bookkeeping and output pulse generation.
  always_comb begin
    state_d        = state_q;
    run_d          = run_q;
    elem_cnt_d     = elem_cnt_q;
    pattern_d      = pattern_q;
    letter_code_d  = letter_code_q;
    letter_valid_d = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_q) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end
      end
      ST_MARK: begin
        if (key_q) begin
          run_d = run_inc;
        end else if ((elem_cnt_q == MAX_ELEMS) || (run_q > DASH_LIM)) begin
          // Overflow and over-long marks both discard the letter.
          err_d   = 1'b1;
          state_d = ST_ERR_WAIT;
          run_d   = RUN_ONE;
        end else begin
          pattern_d  = {pattern_q[2:0], (run_q > DOT_LIM) ? ELEM_DASH : ELEM_DOT};
          elem_cnt_d = elem_cnt_q + 3'd1;
          state_d    = ST_SPACE;
          run_d      = RUN_ONE;
        end
      end
      ST_SPACE: begin
        if (key_q) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end else begin
          run_d = run_inc;
          if (run_inc >= GAP_LIM) begin
            if (lut_hit) begin
              letter_valid_d = 1'b1;
              letter_code_d  = lut_code;
            end else begin
              err_d = 1'b1;
            end
            state_d    = ST_IDLE;
            run_d      = '0;
            elem_cnt_d = '0;
            pattern_d  = '0;
          end
        end
      end
      ST_ERR_WAIT: begin
        if (key_q) begin
          run_d = '0;
        end else begin
          run_d = run_inc;
          if (run_inc >= GAP_LIM) begin
            state_d    = ST_IDLE;
            run_d      = '0;
            elem_cnt_d = '0;
            pattern_d  = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, input register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      key_q          <= 1'b0;
      run_q          <= '0;
      elem_cnt_q     <= '0;
      pattern_q      <= '0;
      letter_valid_q <= 1'b0;
      err_q          <= 1'b0;
      letter_code_q  <= '0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_in;
      run_q          <= run_d;
      elem_cnt_q     <= elem_cnt_d;
      pattern_q      <= pattern_d;
      letter_valid_q <= letter_valid_d;
      err_q          <= err_d;
      letter_code_q  <= letter_code_d;
    end
  end

  assign letter_valid = letter_valid_q;
  assign err          = err_q;
  assign letter_code  = letter_code_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: run-length/element-string reference model checked
// every cycle, plus literal expectations for the classic letter sequences.
module tb_morse_decoder;

  localparam int DOT_MAX  = 1;
  localparam int DASH_MAX = 4;
  localparam int GAP_MIN  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       letter_valid;
  logic [4:0] letter_code;
  logic       err;
  logic       busy;

  always #5 clk = ~clk;

  morse_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .letter_valid (letter_valid),
    .letter_code  (letter_code),
    .err          (err),
    .busy         (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit check_en    = 0;

  // Reference model state: what the decoder has seen so far, in Morse terms.
  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  bit         m_kq;
  int         m_ones, m_zeros;
  bit         m_active, m_bad;
  string      m_elems;
  bit         e_valid, e_err, e_busy;
  logic [4:0] e_code;

  // DUT-side observations for the literal checks.
  int         n_valid = 0, n_err = 0;
  int         last_valid_cyc = 0, last_one_cyc = 0;
  logic [4:0] codes [$];

  function automatic int lookup(string s);
    for (int i = 0; i < 26; i++) if (MORSE[i] == s) return i;
    return -1;
  endfunction

  // Seven letters per bank of eight, starting at 1.
  function automatic logic [4:0] code_of(int idx);
    return 5'((idx / 7) * 8 + (idx % 7) + 1);
  endfunction

  task automatic model_edge(input bit r, input bit k);
    int idx;
    if (r) begin
      m_kq = 0; m_ones = 0; m_zeros = 0; m_active = 0; m_bad = 0; m_elems = "";
      e_valid = 0; e_err = 0; e_code = 5'd0;
    end else begin
      e_valid = 0;
      e_err   = 0;
      if (m_kq) begin
        if (!m_active) begin
          m_active = 1; m_bad = 0; m_elems = "";
        end
        m_ones++;
        m_zeros = 0;
      end else begin
        m_zeros++;
        if (m_active && m_ones > 0 && !m_bad) begin
          if (m_ones > DASH_MAX || m_elems.len() == 4) begin
            m_bad = 1;
            e_err = 1;
          end else if (m_ones <= DOT_MAX) begin
            m_elems = {m_elems, "."};
          end else begin
            m_elems = {m_elems, "-"};
          end
        end
        m_ones = 0;
        if (m_active && m_zeros == GAP_MIN) begin
          if (!m_bad) begin
            idx = lookup(m_elems);
            if (idx >= 0) begin
              e_valid = 1;
              e_code  = code_of(idx);
            end else begin
              e_err = 1;
            end
          end
          m_active = 0; m_bad = 0; m_elems = "";
        end
      end
      m_kq = k;
    end
    e_busy = m_active;
  endtask

  // Every-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if ({letter_valid, err, busy, letter_code} !== {e_valid, e_err, e_busy, e_code}) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: valid/err/busy/code got %b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, letter_valid, err, busy, letter_code, e_valid, e_err, e_busy, e_code);
      end
      if (letter_valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        codes.push_back(letter_code);
      end
      if (err === 1'b1) n_err++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit k, input bit r);
    key_in = k;
    rst    = r;
    @(posedge clk);
    cyc++;
    model_edge(r, k);
    if (k && !r) last_one_cyc = cyc;
    #1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i] == 8'h31, 1'b0);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic send_letter(input int idx);
    string p;
    p = MORSE[idx];
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == 8'h2e) step(1'b1, 1'b0);
      else for (int j = 0; j < int'($urandom_range(2, DASH_MAX)); j++) step(1'b1, 1'b0);
      if (i != p.len() - 1) zeros(int'($urandom_range(1, GAP_MIN - 1)));
    end
  endtask

  int nv0, ne0;

  initial begin
    key_in = 1'b0;
    rst    = 1'b1;
    step(1'b0, 1'b1);
    check_en = 1;
    step(1'b0, 1'b1);
    check("reset busy", int'(busy), 0);
    check("reset code", int'(letter_code), 0);
    check("reset pulses", int'(letter_valid) + int'(err), 0);
    zeros(4);

    // A with pulse latency
    nv0 = n_valid; ne0 = n_err;
    send("10111"); zeros(6);
    check("A count", n_valid - nv0, 1);
    check("A code", int'(codes[$]), 5'b00001);
    check("A err", n_err - ne0, 0);
    check("A latency", last_valid_cyc - last_one_cyc, 4);

    // Q: full four elements without overflow
    nv0 = n_valid;
    send("1110111010111"); zeros(6);
    check("Q count", n_valid - nv0, 1);
    check("Q code", int'(codes[$]), 5'b10011);

    // S then O separated by a minimal letter gap
    nv0 = n_valid;
    send("1010100011101110111"); zeros(6);
    check("SO count", n_valid - nv0, 2);
    check("S code", int'(codes[codes.size() - 2]), 5'b10101);
    check("O code", int'(codes[$]), 5'b10001);

    // Over-long mark, then E
    nv0 = n_valid; ne0 = n_err;
    send("111111"); zeros(6);
    check("long err", n_err - ne0, 1);
    check("long valid", n_valid - nv0, 0);
    send("1"); zeros(6);
    check("E code", int'(codes[$]), 5'b00101);

    // Five dots: overflow error at the fifth mark end, busy until the gap
    nv0 = n_valid; ne0 = n_err;
    send("101010101"); zeros(2);
    check("ovf err pulse", int'(err), 1);
    check("ovf busy", int'(busy), 1);
    zeros(6);
    check("ovf busy after gap", int'(busy), 0);
    check("ovf err count", n_err - ne0, 1);
    check("ovf valid", n_valid - nv0, 0);

    // Unassigned ..--
    nv0 = n_valid; ne0 = n_err;
    send("10101110111"); zeros(6);
    check("..-- err", n_err - ne0, 1);
    check("..-- valid", n_valid - nv0, 0);

    // Reset during the second mark of M, then T
    nv0 = n_valid; ne0 = n_err;
    send("111011");
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst busy", int'(busy), 0);
    check("rst code", int'(letter_code), 0);
    zeros(6);
    check("rst pulses", (n_valid - nv0) + (n_err - ne0), 0);
    send("111"); zeros(6);
    check("T code", int'(codes[$]), 5'b10110);

    // Randomized letters with injected junk and occasional resets
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 15))
        0, 1: for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                step(1'($urandom_range(0, 1)), 1'b0);
        2:    for (int i = 0; i < int'($urandom_range(5, 9)); i++) step(1'b1, 1'b0);
        3:    begin send_letter(int'($urandom_range(0, 25))); step(1'b0, 1'b1); end
        default: send_letter(int'($urandom_range(0, 25)));
      endcase
      zeros(int'($urandom_range(GAP_MIN, GAP_MIN + 3)));
    end
    zeros(6);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
